// File: rtl/argmax_classifier_int8.sv
// rtl/argmax_classifier_int8.sv - sequential signed INT8 argmax over a captured score vector
// Captures one vector in IDLE, scans one element per cycle, reports winner with a done pulse.
module argmax_classifier_int8 #(
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [NUM_CLASSES*8-1:0] in_vec,
  input  logic                     ovr_clr,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         class_idx,
  output logic [7:0]               max_val,
  output logic                     overrun
);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t                   state_q, state_d;
  logic [NUM_CLASSES*8-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]         cur_idx_q, cur_idx_d;
  logic signed [7:0]        best_val_q, best_val_d;
  logic [IDX_W-1:0]         best_idx_q, best_idx_d;
  logic [IDX_W-1:0]         class_idx_q, class_idx_d;
  logic [7:0]               max_val_q, max_val_d;
  logic                     done_q, done_d;
  logic                     overrun_q, overrun_d;

  logic signed [7:0]        cur_elem;
  logic                     last_elem;
  logic                     cand_gt;
  logic                     accept;
  logic                     ovr_event;

  always_comb begin
    cur_elem = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (cur_idx_q == IDX_W'(i)) cur_elem = buf_q[i*8 +: 8];
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  assign cand_gt   = cur_elem > best_val_q;
  assign last_elem = (cur_idx_q == IDX_W'(NUM_CLASSES - 1));
  assign accept    = (state_q == S_IDLE) && in_valid;
  assign ovr_event = (state_q == S_SCAN) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_SCAN;
      S_SCAN:  if (last_elem) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SCAN);
  end

  always_comb begin
    buf_d       = buf_q;
    cur_idx_d   = cur_idx_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    class_idx_d = class_idx_q;
    max_val_d   = max_val_q;
    done_d      = 1'b0;
    if (accept) begin
      buf_d      = in_vec;
      best_val_d = in_vec[7:0];
      best_idx_d = '0;
      cur_idx_d  = IDX_W'(1);
    end else if (state_q == S_SCAN) begin
      if (cand_gt) begin
        best_val_d = cur_elem;
        best_idx_d = cur_idx_q;
      end
      cur_idx_d = cur_idx_q + IDX_W'(1);
      if (last_elem) begin
        class_idx_d = cand_gt ? cur_idx_q : best_idx_q;
        max_val_d   = cand_gt ? cur_elem : best_val_q;
        done_d      = 1'b1;
        cur_idx_d   = '0;
      end
    end
  end

  // Set wins over clear when both land on the same edge.
  always_comb begin
    overrun_d = ovr_clr ? 1'b0 : overrun_q;
    if (ovr_event) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      cur_idx_q   <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      class_idx_q <= '0;
      max_val_q   <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cur_idx_q   <= cur_idx_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      class_idx_q <= class_idx_d;
      max_val_q   <= max_val_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign done      = done_q;
  assign class_idx = class_idx_q;
  assign max_val   = max_val_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_argmax_classifier_int8.sv
// tb/tb_argmax_classifier_int8.sv - directed self-checking bench for argmax_classifier_int8
module tb_argmax_classifier_int8;

  localparam int N = 10;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [N*8-1:0] in_vec = '0;
  logic           ovr_clr = 1'b0;
  logic           busy;
  logic           done;
  logic [W-1:0]   class_idx;
  logic [7:0]     max_val;
  logic           overrun;

  int checks = 0;
  int failures = 0;

  argmax_classifier_int8 #(.NUM_CLASSES(N), .IDX_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec(in_vec), .ovr_clr(ovr_clr),
    .busy(busy), .done(done), .class_idx(class_idx), .max_val(max_val), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [N*8-1:0] mk(input int e0, input int e1, input int e2, input int e3,
                                        input int e4, input int e5, input int e6, input int e7,
                                        input int e8, input int e9);
    return {8'(e9), 8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents vec at the next edge (E0), then runs to E9 checking busy/done each cycle and the result.
  task automatic run_scan(input logic [N*8-1:0] vec, input int exp_idx, input int exp_val, input string name);
    in_valid = 1'b1;
    in_vec   = vec;
    step();
    in_valid = 1'b0;
    in_vec   = ~vec;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_e0 got=%0b exp=1", name, busy); end
    for (int k = 1; k <= N - 1; k++) begin
      step();
      if (k < N - 1) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          failures++; $display("FAIL %s mid_scan k=%0d busy=%0b done=%0b exp busy=1 done=0", name, k, busy, done);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL %s done_at_e9 done=%0b busy=%0b exp done=1 busy=0", name, done, busy);
    end
    checks++;
    if (class_idx !== W'(exp_idx) || max_val !== 8'(exp_val)) begin
      failures++; $display("FAIL %s result idx=%0d val=%0d exp idx=%0d val=%0d", name, class_idx, $signed(max_val), exp_idx, exp_val);
    end
    step();
    checks++;
    if (done !== 1'b0 || class_idx !== W'(exp_idx)) begin
      failures++; $display("FAIL %s after_done done=%0b idx=%0d exp done=0 idx=%0d", name, done, class_idx, exp_idx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    #2 rst_n = 1'b1;
    checks++;
    if ({busy, done, overrun} !== 3'b000 || class_idx !== '0 || max_val !== 8'h00) begin
      failures++; $display("FAIL reset_outputs busy=%0b done=%0b ovr=%0b idx=%0d val=%0d exp all 0", busy, done, overrun, class_idx, max_val);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL reset_idle k=%0d busy=%0b done=%0b exp 0", k, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    run_scan(mk(3, -5, 7, 100, -128, 42, 0, 99, 127, 1), 8, 127, "basic");
  endtask

  task automatic test_ties_negative();
    run_scan(mk(-3, -3, -7, -10, -20, -30, -40, -50, -60, -128), 0, -3, "tie_first");
    run_scan(mk(-128, -128, -128, -128, -128, -128, -128, -128, -2, -2), 8, -2, "tie_last");
    run_scan(mk(-1, -128, 0, -1, -128, -1, -128, -1, -128, -1), 2, 0, "zero_beats_neg");
  endtask

  task automatic test_overrun();
    logic [N*8-1:0] v1;
    v1 = mk(1, 2, 3, 4, 5, 50, 6, 7, 8, 9);
    in_valid = 1'b1;
    in_vec   = v1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    in_valid = 1'b1;
    in_vec   = mk(120, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    in_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL ovr_set ovr=%0b busy=%0b exp 1 1", overrun, busy);
    end
    for (int k = 5; k <= 9; k++) step();
    checks++;
    if (done !== 1'b1 || class_idx !== W'(5) || max_val !== 8'd50) begin
      failures++; $display("FAIL ovr_result done=%0b idx=%0d val=%0d exp 1 5 50", done, class_idx, max_val);
    end
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
    in_valid = 1'b1;
    in_vec   = v1;
    step();
    step();
    ovr_clr = 1'b1;
    step();
    ovr_clr  = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%0b exp=1", overrun); end
    for (int k = 3; k <= 9; k++) step();
    checks++;
    if (done !== 1'b1 || class_idx !== W'(5)) begin
      failures++; $display("FAIL ovr_second_result done=%0b idx=%0d exp 1 5", done, class_idx);
    end
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_vec   = mk(10, 20, 90, 30, 40, 50, 60, 70, 80, 5);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    checks++;
    if (done !== 1'b1 || class_idx !== W'(2) || max_val !== 8'd90) begin
      failures++; $display("FAIL b2b_first done=%0b idx=%0d val=%0d exp 1 2 90", done, class_idx, max_val);
    end
    in_valid = 1'b1;
    in_vec   = mk(1, 2, 3, 4, 5, 6, 77, 7, -8, 9);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || class_idx !== W'(2)) begin
        failures++; $display("FAIL b2b_hold k=%0d done=%0b busy=%0b idx=%0d exp 0 1 2", k, done, busy, class_idx);
      end
      step();
    end
    step();
    checks++;
    if (done !== 1'b1 || class_idx !== W'(6) || max_val !== 8'd77 || overrun !== 1'b0) begin
      failures++; $display("FAIL b2b_second done=%0b idx=%0d val=%0d ovr=%0b exp 1 6 77 0", done, class_idx, max_val, overrun);
    end
    step();
  endtask

  task automatic test_reset_mid_scan();
    in_valid = 1'b1;
    in_vec   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 55);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || class_idx !== '0 || max_val !== 8'h00) begin
      failures++; $display("FAIL midreset_async busy=%0b done=%0b idx=%0d val=%0d exp all 0", busy, done, class_idx, max_val);
    end
    step();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL midreset_no_done k=%0d done=%0b busy=%0b exp 0 0", k, done, busy);
      end
    end
    run_scan(mk(-9, 4, 4, -1, 12, 11, 12, 0, -128, 127), 9, 127, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties_negative();
    test_overrun();
    test_back_to_back();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
